// File: rtl/booth_radix8_seq_multiplier_if.sv
// Operand, encoder and product signals of the radix-8 Booth sequencer.
// The slave modport is the multiplier itself; the master modport is its
// environment (operand source, combinational Booth encoder, product sink).
interface booth_radix8_seq_multiplier_if #(
  parameter int WIDTH = 32
);
  localparam int PW = 2 * WIDTH;

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] seg_data;
  logic [3:0]       seg;
  logic [PW-1:0]    pp;
  logic             out_valid;
  logic             out_ready;
  logic [PW-1:0]    out_product;

  modport master (
    output in_valid, in_a, in_b, pp, out_ready,
    input  in_ready, seg_data, seg, out_valid, out_product
  );

  modport slave (
    input  in_valid, in_a, in_b, pp, out_ready,
    output in_ready, seg_data, seg, out_valid, out_product
  );
endinterface

// File: rtl/booth_radix8_seq_multiplier.sv
// Iterative signed 32x32 multiplier built around an external radix-8 Booth
// partial-product encoder. The multiplier is recoded into eleven overlapping
// 4-bit windows, one per cycle; each returned partial product is shifted by
// 3*digit and accumulated into a 64-bit two's-complement result.
// Only WIDTH = 32 is supported (11 digits, 64-bit product).
module booth_radix8_seq_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst_n,
  booth_radix8_seq_multiplier_if.slave  bus
);
  localparam int PW   = 2 * WIDTH;
  localparam int NDIG = 11;
  localparam int MW   = WIDTH + 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] seg_data_q;
  logic [MW-1:0]    mreg;
  logic [PW-1:0]    acc;
  logic [3:0]       cnt;
  logic             accept;
  logic [5:0]       shamt;
  logic [PW-1:0]    pp_shifted;

  // The encoder always sees the multiplicand captured at the last accept.
  assign bus.seg_data = seg_data_q;

  // Digit i has weight 8^i, so its partial product lands 3*i bits up.
  assign shamt      = 6'(cnt) * 6'd3;
  assign pp_shifted = bus.pp << shamt;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode plus handshake, window and product outputs.
  always_comb begin
    state_next      = state;
    accept          = 1'b0;
    bus.in_ready    = 1'b0;
    bus.out_valid   = 1'b0;
    bus.out_product = '0;
    bus.seg         = 4'b0000;
    case (state)
      IDLE: begin
        bus.in_ready = 1'b1;
        accept       = bus.in_valid;
        if (bus.in_valid) begin
          state_next = RUN;
        end
      end
      RUN: begin
        bus.seg = mreg[3:0];
        if (cnt == 4'(NDIG - 1)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        bus.out_valid   = 1'b1;
        bus.out_product = acc;
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one Booth digit accumulated per RUN cycle;
  // the multiplier register carries two sign copies above b and a zero b[-1].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_data_q <= '0;
      mreg       <= '0;
      acc        <= '0;
      cnt        <= '0;
    end else if (accept) begin
      seg_data_q <= bus.in_a;
      mreg       <= {bus.in_b[WIDTH-1], bus.in_b[WIDTH-1], bus.in_b, 1'b0};
      acc        <= '0;
      cnt        <= '0;
    end else if (state == RUN) begin
      acc  <= acc + pp_shifted;
      mreg <= {{3{mreg[MW-1]}}, mreg[MW-1:3]};
      cnt  <= cnt + 4'd1;
    end
  end
endmodule

// File: doc/booth_radix8_seq_multiplier.md
# booth_radix8_seq_multiplier

Iterative signed 32x32 multiplier sequencer that wraps the radix-8 Booth partial-product encoder. It accepts operand pairs over a valid/ready handshake and recodes the multiplier into eleven overlapping 4-bit windows, issuing one per cycle to the encoder. Each returned 64-bit partial product is shifted and accumulated, and the block presents the 64-bit two's-complement product on a valid/ready output.

## Interface
- WIDTH, 32: operand width. Only 32 is supported; it fixes the digit count at 11 and the product width at 64.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  block can accept an operand pair (high only in IDLE).
- in_a  in  32  multiplicand, signed.
- in_b  in  32  multiplier, signed.
- seg_data  out  32  registered multiplicand, driven to the encoder data input.
- seg  out  4  current Booth window, driven to the encoder segment input.
- pp  in  64  partial product returned combinationally by the encoder for (seg_data, seg).
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- out_product  out  64  signed product a*b.

## Operation
- Encoder contract: pp = sign_ext64(seg_data) * d mod 2^64, where d = -4*seg[3] + 2*seg[2] + seg[1] + seg[0], d in [-4, +4].
- State machine: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1, seg=4'b0000.
  - On in_valid&&in_ready: seg_data<=in_a; mreg (35 bits) <= {in_b[31], in_b[31], in_b, 1'b0}; acc<=0; cnt<=0; go to RUN.
- RUN:
  - seg = mreg[3:0].
  - Each cycle: acc <= acc + (pp << 3*cnt), truncated to 64 bits; mreg <= mreg arithmetic-shifted right by 3; cnt <= cnt+1.
  - When cnt==10 (11th digit), go to DONE.
- Window i covers multiplier bits {b[3i+2], b[3i+1], b[3i], b[3i-1]}, with b[-1]=0 and bits above 31 sign-extended. The sum over i=0..10 of d_i*8^i equals signed in_b.
- DONE:
  - out_valid=1, out_product=acc, seg=4'b0000, in_ready=0.
  - Hold all outputs stable until out_ready is high; on out_valid&&out_ready, go to IDLE.
- seg_data stays stable from accept until the next accept.
- in_a and in_b are ignored whenever in_ready=0.
- Arithmetic is modulo 2^64 throughout. The result is exact for all signed 32-bit pairs, including -2^31 * -2^31.

## Timing
- Reset values (asynchronous): state=IDLE, in_ready=1, out_valid=0, out_product=0, seg=0, seg_data=0, acc=0, cnt=0.
- Latency:
  - Accept at edge E0.
  - RUN occupies cycles after E0 through E11.
  - out_valid is high in the cycle after E11, i.e. 11 cycles after the accept edge.
- Throughput: with out_ready held high, one product every 13 cycles (accept cycle, 11 RUN, 1 DONE).
- pp is sampled in the same cycle seg is driven. The encoder path is combinational and must close within one clock period including the accumulator add.
- out_ready high before DONE has no effect; the transfer occurs only when out_valid is high.
- Reset asserted mid-RUN or mid-DONE aborts the operation: the partial result is discarded and out_valid drops immediately. After release the block is in IDLE with in_ready=1.
- in_valid high in the same cycle as the DONE handshake is not accepted. in_ready rises the following cycle.

## Test plan
- Reset: assert rst_n=0 in RUN cycle 5 -> out_valid=0, in_ready=1, seg=0, out_product=0 immediately. After release, a=2, b=7 -> out_product=14.
- a=3, b=5:
  - seg sequence is 4'b1010 (d=-3), 4'b0001 (d=+1), then 9 cycles of 4'b0000.
  - out_valid rises 11 cycles after accept with out_product=64'h000000000000000F.
- Extremes:
  - a=32'h80000000, b=32'h80000000 -> 64'h4000000000000000.
  - a=32'hFFFFFFFF, b=32'h7FFFFFFF -> 64'hFFFFFFFF80000001.
  - b=0 -> 0 with all 11 windows 4'b0000.
- Backpressure: out_ready low for 5 cycles in DONE -> out_valid and out_product held, in_ready=0, a concurrent in_valid is ignored. Raise out_ready -> handshake, then IDLE and in_ready=1 next cycle.
- Back-to-back: in_valid and out_ready held high with 100 operand pairs -> one product every 13 cycles, in order.
- Random: 10,000 signed pairs including corner values 0, ±1, -2^31, 2^31-1 -> out_product equals the 64-bit signed reference product every time.
